// File: rtl/se_arbiter.sv
// se_arbiter: round-robin lock of one MAC search engine across NPORT frame processors.
// Latency: req_in -> grant 1 cycle, -> se_req 2 cycles; ack/nak/result return path is combinational.
// Backpressure: owner holds the engine until its req drops, others wait; `SE_ARB_TIMEOUT_EN adds a watchdog nak.
module se_arbiter #(
  parameter int NPORT  = 4,
  parameter int MAC_W  = 48,
  parameter int HASH_W = 10,
  parameter int RES_W  = 16
`ifdef SE_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NPORT-1:0]         req_in,
  input  logic [NPORT-1:0]         source_in,
  input  logic [NPORT*MAC_W-1:0]   mac_in,
  input  logic [NPORT*HASH_W-1:0]  hash_in,
  input  logic [NPORT*16-1:0]      pmap_in,
  output logic [NPORT-1:0]         ack_out,
  output logic [NPORT-1:0]         nak_out,
  output logic [RES_W-1:0]         result_out,
  output logic [NPORT-1:0]         grant,
  output logic                     se_req,
  output logic                     se_source,
  output logic [MAC_W-1:0]         se_mac,
  output logic [HASH_W-1:0]        se_hash,
  output logic [15:0]              se_portmap,
  input  logic                     se_ack,
  input  logic                     se_nak,
  input  logic [RES_W-1:0]         se_result,
  output logic                     timeout
);

  localparam int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] pick;
  logic [PTR_W-1:0] cand;
  logic             pick_vld;
  logic             in_grant;

  assign in_grant = (state == GRANT);

  // Search requesters starting just after the previous owner; first hit wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NPORT; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % NPORT);
      if (!pick_vld && req_in[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Ownership FSM: grant in IDLE, register the owner's request fields in GRANT,
  // and insert one RELEASE cycle so the engine always sees se_req low between owners.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      rr_ptr     <= PTR_W'(NPORT - 1);
      owner      <= '0;
      grant      <= '0;
      se_req     <= 1'b0;
      se_source  <= 1'b0;
      se_mac     <= '0;
      se_hash    <= '0;
      se_portmap <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner <= pick;
            grant <= NPORT'(1) << pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (req_in[owner]) begin
            se_req     <= 1'b1;
            se_source  <= source_in[owner];
            se_mac     <= mac_in[owner*MAC_W +: MAC_W];
            se_hash    <= hash_in[owner*HASH_W +: HASH_W];
            se_portmap <= pmap_in[owner*16 +: 16];
          end else begin
            se_req <= 1'b0;
            grant  <= '0;
            rr_ptr <= owner;
            state  <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SE_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       wd_hit;

  assign wd_hit  = in_grant && (wd_cnt == 8'(TIMEOUT));
  // A real response in the same cycle takes precedence over the forced nak.
  assign timeout = wd_hit & ~se_ack & ~se_nak;

  // Count silent engine cycles while the owner's request is presented.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt <= '0;
    end else if (!in_grant || se_ack || se_nak || wd_hit) begin
      wd_cnt <= '0;
    end else if (se_req) begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Responses reach only the current owner and only while the lock is held.
  always_comb begin
    ack_out    = grant & {NPORT{se_ack & in_grant}};
    nak_out    = grant & {NPORT{in_grant & ~se_ack & (se_nak | timeout)}};
    result_out = se_result;
  end

endmodule

// File: tb/tb_se_arbiter.sv
`timescale 1ns/1ps
module tb_se_arbiter;
  localparam int NPORT  = 4;
  localparam int MAC_W  = 48;
  localparam int HASH_W = 10;
  localparam int RES_W  = 16;

  logic                     clk = 1'b0;
  logic                     rstn = 1'b0;
  logic [NPORT-1:0]         req_in = '0;
  logic [NPORT-1:0]         source_in = '0;
  logic [NPORT*MAC_W-1:0]   mac_in = '0;
  logic [NPORT*HASH_W-1:0]  hash_in = '0;
  logic [NPORT*16-1:0]      pmap_in = '0;
  logic [NPORT-1:0]         ack_out, nak_out, grant;
  logic [RES_W-1:0]         result_out;
  logic                     se_req, se_source, timeout;
  logic [MAC_W-1:0]         se_mac;
  logic [HASH_W-1:0]        se_hash;
  logic [15:0]              se_portmap;
  logic                     se_ack = 1'b0;
  logic                     se_nak = 1'b0;
  logic [RES_W-1:0]         se_result = '0;

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard: expected results per requester, in response order
  logic [RES_W-1:0] exp_q[NPORT][$];
  int               ack_cnt[NPORT];
  logic [NPORT-1:0] order_q[$];
  int               gap_q[$];
  logic [NPORT-1:0] prev_grant = '0;
  int               zrun = 0;
  bit               seen_owner = 0;

  // engine model controls
  bit eng_en = 0;
  int eng_dly = 3;
  int eng_cnt = 0;
  bit sv_learn = 0, sv_look = 0;

  se_arbiter #(
    .NPORT(NPORT), .MAC_W(MAC_W), .HASH_W(HASH_W), .RES_W(RES_W)
`ifdef SE_ARB_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk(clk), .rstn(rstn), .req_in(req_in), .source_in(source_in),
    .mac_in(mac_in), .hash_in(hash_in), .pmap_in(pmap_in),
    .ack_out(ack_out), .nak_out(nak_out), .result_out(result_out),
    .grant(grant), .se_req(se_req), .se_source(se_source), .se_mac(se_mac),
    .se_hash(se_hash), .se_portmap(se_portmap), .se_ack(se_ack),
    .se_nak(se_nak), .se_result(se_result), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engine: answers each learn and each lookup once, eng_dly cycles after it appears.
  initial forever begin
    @(posedge clk); #1;
    if (eng_en) begin
      se_ack = 1'b0;
      se_nak = 1'b0;
      if (!rstn || !se_req) begin
        eng_cnt = 0; sv_learn = 0; sv_look = 0;
      end else if ((se_source && !sv_learn) || (!se_source && !sv_look)) begin
        eng_cnt++;
        if (eng_cnt >= eng_dly) begin
          se_ack    = 1'b1;
          se_result = se_source ? se_portmap : se_mac[15:0];
          if (se_source) sv_learn = 1; else sv_look = 1;
          eng_cnt = 0;
        end
      end
    end
  end

  // Monitor: pop the scoreboard on every ack, track owner order and idle gaps.
  always @(negedge clk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (ack_out[p]) begin
        ack_cnt[p]++;
        if (exp_q[p].size() == 0) check($sformatf("unexpected_ack_p%0d", p), 64'(ack_out[p]), 64'(0));
        else check($sformatf("result_p%0d", p), 64'(result_out), 64'(exp_q[p].pop_front()));
      end
    end
    if (grant == '0) zrun++;
    else if (prev_grant == '0) begin
      order_q.push_back(grant);
      if (seen_owner) gap_q.push_back(zrun);
      seen_owner = 1;
      zrun = 0;
    end
    prev_grant = grant;
  end

  task automatic clr_mon();
    order_q.delete(); gap_q.delete(); seen_owner = 0; zrun = 0;
    for (int p = 0; p < NPORT; p++) ack_cnt[p] = 0;
  endtask

  task automatic wait_ack(input int p, output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack_out[p]) begin ok = 1; break; end
    end
  endtask

  task automatic wait_grant(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (grant != '0) begin ok = 1; break; end
    end
  endtask

  task automatic wait_sereq(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (se_req) begin ok = 1; break; end
    end
  endtask

  // One full learn+lookup transaction from requester p; owner holds req 'hold' extra cycles.
  task automatic txn(input int p, input logic [47:0] smac, input logic [47:0] dmac,
                     input logic [15:0] pm, input int hold);
    bit ok;
    exp_q[p].push_back(pm);
    exp_q[p].push_back(dmac[15:0]);
    @(posedge clk); #1;
    req_in[p] = 1'b1;
    source_in[p] = 1'b1;
    mac_in[p*MAC_W +: MAC_W] = smac;
    hash_in[p*HASH_W +: HASH_W] = smac[HASH_W-1:0];
    pmap_in[p*16 +: 16] = pm;
    wait_ack(p, ok);
    check($sformatf("learn_ack_seen_p%0d", p), 64'(ok), 64'(1));
    @(posedge clk); #1;
    source_in[p] = 1'b0;
    mac_in[p*MAC_W +: MAC_W] = dmac;
    hash_in[p*HASH_W +: HASH_W] = dmac[HASH_W-1:0];
    wait_ack(p, ok);
    check($sformatf("lookup_ack_seen_p%0d", p), 64'(ok), 64'(1));
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    req_in[p] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [NPORT-1:0] exp_ord[4];
    int k;
    bit nak_seen, to_seen;
    exp_ord = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};

    // reset state: ack/nak held off even with engine pulses present
    se_ack = 1'b1;
    se_nak = 1'b1;
    #12;
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_se_req", 64'(se_req), 64'(0));
    check("rst_ack", 64'(ack_out), 64'(0));
    check("rst_nak", 64'(nak_out), 64'(0));
    check("rst_timeout", 64'(timeout), 64'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    check("idle_ack_dropped", 64'(ack_out), 64'(0));
    se_ack = 1'b0;
    se_nak = 1'b0;
    eng_en = 1;

    // single owner: latency and release timing
    clr_mon();
    fork
      txn(2, 48'h0000_1122_3344, 48'h0000_aaaa_0003, 16'h0004, 0);
      begin
        @(posedge clk); @(negedge clk);
        check("t1_grant_c0", 64'(grant), 64'(0));
        @(negedge clk);
        check("t1_grant_c1", 64'(grant), 64'(4'b0100));
        check("t1_se_req_c1", 64'(se_req), 64'(0));
        @(negedge clk);
        check("t1_se_req_c2", 64'(se_req), 64'(1));
        check("t1_se_source", 64'(se_source), 64'(1));
        check("t1_se_mac", 64'(se_mac), 64'(48'h0000_1122_3344));
        check("t1_se_hash", 64'(se_hash), 64'(10'h344));
        check("t1_se_portmap", 64'(se_portmap), 64'(16'h0004));
      end
    join
    @(negedge clk);
    check("t1_grant_before_drop_seen", 64'(grant), 64'(4'b0100));
    @(negedge clk);
    check("t1_grant_released", 64'(grant), 64'(0));
    check("t1_se_req_released", 64'(se_req), 64'(0));
    check("t1_ack_count", 64'(ack_cnt[2]), 64'(2));

    // fairness from reset: 0 and 3 alternate
    @(posedge clk); #1; rstn = 1'b0;
    @(posedge clk); #1; rstn = 1'b1;
    clr_mon();
    fork
      begin
        txn(0, 48'h10, 48'h0000_0000_0a01, 16'h0101, 0);
        @(posedge clk);
        txn(0, 48'h11, 48'h0000_0000_0a02, 16'h0102, 0);
      end
      begin
        txn(3, 48'h30, 48'h0000_0000_0b01, 16'h0301, 0);
        @(posedge clk);
        txn(3, 48'h31, 48'h0000_0000_0b02, 16'h0302, 0);
      end
    join
    repeat (4) @(posedge clk);
    check("t2_owner_count", 64'(order_q.size()), 64'(4));
    for (int i = 0; i < 4 && i < order_q.size(); i++)
      check($sformatf("t2_owner_%0d", i), 64'(order_q[i]), 64'(exp_ord[i]));
    check("t2_gap_count", 64'(gap_q.size()), 64'(3));
    foreach (gap_q[i]) check($sformatf("t2_idle_gap_%0d", i), 64'(gap_q[i]), 64'(2));

    // no preemption: req 2 arrives while 1 owns
    clr_mon();
    fork
      txn(1, 48'h21, 48'h0000_0000_0c01, 16'h0201, 6);
      begin
        repeat (5) @(posedge clk);
        txn(2, 48'h22, 48'h0000_0000_0c02, 16'h0202, 0);
      end
    join
    repeat (4) @(posedge clk);
    check("t3_owner_count", 64'(order_q.size()), 64'(2));
    if (order_q.size() >= 2) begin
      check("t3_first_owner", 64'(order_q[0]), 64'(4'b0010));
      check("t3_second_owner", 64'(order_q[1]), 64'(4'b0100));
    end
    if (gap_q.size() >= 1) check("t3_idle_gap", 64'(gap_q[0]), 64'(2));
    check("t3_ack_count_p1", 64'(ack_cnt[1]), 64'(2));

    // ack beats nak; late ack in RELEASE/IDLE is dropped
    eng_en = 0;
    @(posedge clk); #1;
    se_ack = 1'b0; se_nak = 1'b0;
    req_in[0] = 1'b1; source_in[0] = 1'b1;
    wait_grant(ok);
    check("t4_grant_seen", 64'(ok), 64'(1));
    check("t4_grant", 64'(grant), 64'(4'b0001));
    @(posedge clk); #1;
    se_ack = 1'b1; se_nak = 1'b1; se_result = 16'hbeef;
    exp_q[0].push_back(16'hbeef);
    @(negedge clk);
    check("t4_ack_wins", 64'(ack_out), 64'(4'b0001));
    check("t4_nak_suppressed", 64'(nak_out), 64'(4'b0000));
    @(posedge clk); #1;
    se_ack = 1'b0;
    @(negedge clk);
    check("t4_nak_alone", 64'(nak_out), 64'(4'b0001));
    check("t4_no_ack", 64'(ack_out), 64'(0));
    @(posedge clk); #1;
    se_nak = 1'b0; req_in[0] = 1'b0;
    @(posedge clk); #1;
    se_ack = 1'b1;
    @(negedge clk);
    check("t4_release_grant", 64'(grant), 64'(0));
    check("t4_release_ack_dropped", 64'(ack_out), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_idle_ack_dropped", 64'(ack_out), 64'(0));
    @(posedge clk); #1;
    se_ack = 1'b0;

    // reset in the middle of the lookup phase
    req_in[2] = 1'b1; source_in[2] = 1'b1;
    mac_in[2*MAC_W +: MAC_W] = 48'h0000_5555_6666;
    wait_sereq(ok);
    check("t5_se_req_seen", 64'(ok), 64'(1));
    @(posedge clk); #1;
    se_result = 16'h1111; exp_q[2].push_back(16'h1111); se_ack = 1'b1;
    @(posedge clk); #1;
    se_ack = 1'b0; source_in[2] = 1'b0;
    @(posedge clk); @(negedge clk);
    check("t5_phase2_source", 64'(se_source), 64'(0));
    @(posedge clk); #1;
    rstn = 1'b0; se_ack = 1'b1; req_in[0] = 1'b1;
    #1;
    check("t5_rst_grant", 64'(grant), 64'(0));
    check("t5_rst_se_req", 64'(se_req), 64'(0));
    check("t5_rst_se_mac", 64'(se_mac), 64'(0));
    check("t5_rst_ack", 64'(ack_out), 64'(0));
    @(posedge clk); #1;
    se_ack = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    wait_grant(ok);
    check("t5_regrant_seen", 64'(ok), 64'(1));
    check("t5_regrant_port0", 64'(grant), 64'(4'b0001));
    @(posedge clk); #1;
    req_in = '0; source_in = '0;
    repeat (4) @(posedge clk);

    // silent engine
    #1;
    req_in[1] = 1'b1; source_in[1] = 1'b1;
    wait_sereq(ok);
    check("t6_se_req_seen", 64'(ok), 64'(1));
`ifdef SE_ARB_TIMEOUT_EN
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (timeout || nak_out != '0) begin k = i; break; end
    end
    check("t6_timeout_cycles", 64'(k), 64'(8));
    check("t6_timeout_nak", 64'(nak_out), 64'(4'b0010));
    check("t6_timeout_pulse", 64'(timeout), 64'(1));
    @(negedge clk);
    check("t6_timeout_one_cycle", 64'(timeout), 64'(0));
    check("t6_grant_kept", 64'(grant), 64'(4'b0010));
`else
    nak_seen = 0; to_seen = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (nak_out != '0) nak_seen = 1;
      if (timeout) to_seen = 1;
    end
    check("t6_no_nak", 64'(nak_seen), 64'(0));
    check("t6_no_timeout", 64'(to_seen), 64'(0));
    check("t6_grant_held", 64'(grant), 64'(4'b0010));
`endif
    @(posedge clk); #1;
    req_in = '0;
    repeat (4) @(posedge clk);

    for (int p = 0; p < NPORT; p++)
      check($sformatf("scoreboard_empty_p%0d", p), 64'(exp_q[p].size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
